// File: rtl/byte_lane_memory_pkg.sv
// Shared definitions for the byte-lane data memory: store size codes,
// handshake FSM states and the lane/alignment helpers used by the top level.
package mem_pkg;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_BYTE = 2'b01;
  localparam logic [1:0] WR_HALF = 2'b10;
  localparam logic [1:0] WR_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    DONE  = 2'b10
  } mem_state_t;

  // A halfword must sit on an even byte, a word on a row boundary.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    return ((size == WR_HALF) && offset[0]) || ((size == WR_WORD) && (offset != 2'b00));
  endfunction

  // Number of lanes a store of the given size writes.
  function automatic logic [2:0] lane_count(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      WR_BYTE: n = 3'd1;
      WR_HALF: n = 3'd2;
      WR_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // Inverse of the rotation: which data lane feeds a given bank.
  function automatic logic [1:0] lane_of_bank(input logic [1:0] bank, input logic [1:0] offset);
    return bank - offset;
  endfunction

endpackage

// File: rtl/byte_lane_memory_if.sv
// Core-side bus of the byte-lane data memory. The core is the master; the
// memory answers as the slave. d3/q3 carry the least significant byte.
interface byte_lane_memory_if;

  logic [31:0] address;
  logic [1:0]  write;
  logic [7:0]  d3, d2, d1, d0;
  logic [7:0]  q3, q2, q1, q0;
  logic        done;
  logic        error;

  modport master (
    output address, write, d3, d2, d1, d0,
    input  q3, q2, q1, q0, done, error
  );

  modport slave (
    input  address, write, d3, d2, d1, d0,
    output q3, q2, q1, q0, done, error
  );

endinterface

// File: rtl/byte_lane_memory_bank.sv
// One byte-wide bank of the data memory: simple dual-port synchronous RAM,
// separate write and read rows, read-first when both hit the same row.
// No reset on the array or the read register so it maps onto block RAM.
module byte_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ROW_W       = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ROW_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [ROW_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [DEPTH_WORDS];

  // Write the addressed row and register the old contents of the read row.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/byte_lane_memory.sv
// Data memory responder for the multi-cycle core. Four byte banks share one
// row address; reads rotate the banks so the addressed byte lands on lane 0
// (q3), and stores go through an IDLE/WRITE/DONE handshake that holds done
// until the core drops its request.
module byte_lane_memory
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ROW_W       = 10
) (
  input  logic                clk,
  input  logic                rst,
  byte_lane_memory_if.slave   bus
);

  mem_state_t       state;
  mem_state_t       next_state;

  logic [7:0]       in_lane [4];
  logic [ROW_W-1:0] cap_row;
  logic [1:0]       cap_off;
  logic [1:0]       cap_size;
  logic [7:0]       cap_lane [4];
  logic             capture;
  logic             do_write;
  logic             store_bad;
  logic             error_q;

  logic [ROW_W-1:0] rd_row;
  logic [1:0]       rd_off;
  logic             rd_valid;
  logic [7:0]       out_lane [4];

  logic [3:0]       bank_we;
  logic [7:0]       bank_wdata [4];
  logic [7:0]       bank_rdata [4];

  logic             unused_addr_bits;

  assign in_lane[0] = bus.d3;
  assign in_lane[1] = bus.d2;
  assign in_lane[2] = bus.d1;
  assign in_lane[3] = bus.d0;

  assign rd_row           = bus.address[ROW_W+1:2];
  assign unused_addr_bits = ^bus.address[31:ROW_W+2];
  assign store_bad        = misaligned(cap_size, cap_off);

  // Handshake state register; reset drops straight to IDLE, aborting a store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: one WRITE cycle per request, then wait in DONE for release.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = (bus.write != WR_NONE) ? WRITE : IDLE;
      WRITE:   next_state = DONE;
      DONE:    next_state = (bus.write != WR_NONE) ? DONE : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: capture strobe in IDLE, bank write in WRITE, done in DONE.
  always_comb begin
    capture  = 1'b0;
    do_write = 1'b0;
    bus.done = 1'b0;
    case (state)
      IDLE:    capture  = (bus.write != WR_NONE);
      WRITE:   do_write = !store_bad;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // Latch the whole request so later bus changes cannot disturb the store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_row  <= '0;
      cap_off  <= 2'b00;
      cap_size <= WR_NONE;
      for (int i = 0; i < 4; i++) begin
        cap_lane[i] <= 8'h00;
      end
    end else if (capture) begin
      cap_row  <= rd_row;
      cap_off  <= bus.address[1:0];
      cap_size <= bus.write;
      for (int i = 0; i < 4; i++) begin
        cap_lane[i] <= in_lane[i];
      end
    end
  end

  // Alignment flag is refreshed only when a store reaches WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_q <= 1'b0;
    end else if (state == WRITE) begin
      error_q <= store_bad;
    end
  end

  assign bus.error = error_q;

  // Route each captured lane to its bank and enable only the lanes in the store.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      bank_wdata[b] = cap_lane[lane_of_bank(2'(b), cap_off)];
      bank_we[b]    = do_write &&
                      ({1'b0, lane_of_bank(2'(b), cap_off)} < lane_count(cap_size));
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_bank
    byte_bank #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ROW_W       (ROW_W)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[b]),
      .waddr (cap_row),
      .wdata (bank_wdata[b]),
      .raddr (rd_row),
      .rdata (bank_rdata[b])
    );
  end

  // Keep the byte offset of the read in flight; rd_valid masks the
  // uninitialised bank outputs so q reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_off   <= 2'b00;
      rd_valid <= 1'b0;
    end else begin
      rd_off   <= bus.address[1:0];
      rd_valid <= 1'b1;
    end
  end

  // Rotate the banks so the addressed byte comes out on lane 0.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      out_lane[i] = rd_valid ? bank_rdata[2'(rd_off + 2'(i))] : 8'h00;
    end
  end

  assign bus.q3 = out_lane[0];
  assign bus.q2 = out_lane[1];
  assign bus.q1 = out_lane[2];
  assign bus.q0 = out_lane[3];

endmodule

// File: tb/tb_byte_lane_memory.sv
// Self-checking bench for byte_lane_memory: a table of stores and reads with
// hand-computed expected words, plus sequences for a held request and a
// reset that lands in the WRITE cycle.
module tb_byte_lane_memory;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  byte_lane_memory_if bus ();

  byte_lane_memory #(
    .DEPTH_WORDS (1024),
    .ROW_W       (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          is_store;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
    logic [31:0] exp_q;
    logic        exp_err;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic        err;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void addStore(input logic [31:0] addr, input logic [1:0] size,
                                   input logic [31:0] data, input logic exp_err,
                                   input string name);
    vec_t v;
    v.is_store = 1'b1; v.addr = addr; v.size = size; v.data = data;
    v.exp_q = 32'h0; v.exp_err = exp_err; v.name = name;
    vecs.push_back(v);
  endfunction

  function automatic void addRead(input logic [31:0] addr, input logic [31:0] exp_q,
                                  input logic exp_err, input string name);
    vec_t v;
    v.is_store = 1'b0; v.addr = addr; v.size = WR_NONE; v.data = 32'h0;
    v.exp_q = exp_q; v.exp_err = exp_err; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic setData(input logic [31:0] data);
    bus.d3 = data[7:0];
    bus.d2 = data[15:8];
    bus.d1 = data[23:16];
    bus.d0 = data[31:24];
  endtask

  function automatic logic [31:0] readWord();
    return {bus.q0, bus.q1, bus.q2, bus.q3};
  endfunction

  // Issue a read at the next falling edge and queue what it must return.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] exp_q,
                               input logic exp_err, input string name);
    exp_t e;
    @(negedge clk);
    bus.address = addr;
    bus.write   = WR_NONE;
    e.q = exp_q; e.err = exp_err; e.name = name;
    sb.push_back(e);
  endtask

  // After the sampling edge, pop the oldest expectation and compare.
  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty actual=0 expected=1");
    end else begin
      e = sb.pop_front();
      check({e.name, "_q"}, readWord(), e.q);
      check({e.name, "_err"}, 32'(bus.error), 32'(e.err));
    end
  endtask

  // Full store handshake: done low after the request edge, high one edge
  // later, low again once the released request is sampled.
  task automatic doStore(input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] data, input logic exp_err, input string name);
    @(negedge clk);
    bus.address = addr;
    bus.write   = size;
    setData(data);
    @(posedge clk);
    #1;
    check({name, "_done_edge1"}, 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    check({name, "_done_edge2"}, 32'(bus.done), 32'd1);
    @(negedge clk);
    bus.write = WR_NONE;
    @(posedge clk);
    #1;
    check({name, "_done_release"}, 32'(bus.done), 32'd0);
    check({name, "_err"}, 32'(bus.error), 32'(exp_err));
  endtask

  // Watchdog so the run always ends even if a sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    bus.address = 32'h0;
    bus.write   = WR_NONE;
    setData(32'h0);

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_q", readWord(), 32'h0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_err", 32'(bus.error), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table of stores and reads with hand-derived expectations.
    addStore(32'h10, WR_WORD, 32'h11223344, 1'b0, "st_w10");
    addRead (32'h10, 32'h11223344, 1'b0, "rd_10");
    addStore(32'h12, WR_BYTE, 32'h000000AA, 1'b0, "st_b12");
    addRead (32'h10, 32'h11AA3344, 1'b0, "rd_10_after_b");
    addRead (32'h12, 32'h334411AA, 1'b0, "rd_12");
    addRead (32'h13, 32'hAA334411, 1'b0, "rd_13");
    addStore(32'h14, WR_WORD, 32'h55667788, 1'b0, "st_w14");
    addStore(32'h16, WR_HALF, 32'h0000BEEF, 1'b0, "st_h16");
    addRead (32'h16, 32'h7788BEEF, 1'b0, "rd_16");
    addRead (32'h14, 32'hBEEF7788, 1'b0, "rd_14");
    addStore(32'h20, WR_WORD, 32'h01020304, 1'b0, "st_w20");
    addStore(32'h21, WR_WORD, 32'hDEADBEEF, 1'b1, "st_w21_bad");
    addRead (32'h20, 32'h01020304, 1'b1, "rd_20_untouched");
    addStore(32'h13, WR_HALF, 32'h0000CAFE, 1'b1, "st_h13_bad");
    addRead (32'h10, 32'h11AA3344, 1'b1, "rd_10_untouched");
    addStore(32'h24, WR_WORD, 32'hCAFEF00D, 1'b0, "st_w24_clear");
    addRead (32'h24, 32'hCAFEF00D, 1'b0, "rd_24");
    addStore(32'h22, WR_HALF, 32'h00005A6B, 1'b0, "st_h22");
    addRead (32'h20, 32'h5A6B0304, 1'b0, "rd_20_after_h");
    addRead (32'h21, 32'h045A6B03, 1'b0, "rd_21_rotated");
    addStore(32'h27, WR_BYTE, 32'h00000077, 1'b0, "st_b27");
    addRead (32'h24, 32'h77FEF00D, 1'b0, "rd_24_after_b");
    addStore(32'hFFC, WR_WORD, 32'hA1B2C3D4, 1'b0, "st_w_lastrow");
    addRead (32'hFFFF_FFFC, 32'hA1B2C3D4, 1'b0, "rd_lastrow_wrap");
    addRead (32'h1010, 32'h11AA3344, 1'b0, "rd_10_wrap");
    addStore(32'h30, WR_WORD, 32'h00000000, 1'b0, "st_w30_init");
    addStore(32'h34, WR_WORD, 32'h12345678, 1'b0, "st_w34_init");
    addStore(32'h40, WR_WORD, 32'h99887766, 1'b0, "st_w40_init");

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_store) begin
        doStore(vecs[i].addr, vecs[i].size, vecs[i].data, vecs[i].exp_err, vecs[i].name);
      end else begin
        applyStimulus(vecs[i].addr, vecs[i].exp_q, vecs[i].exp_err, vecs[i].name);
        checkOutput();
      end
    end

    // Held request: ten edges of write=word while the bus changes after capture.
    @(negedge clk);
    bus.address = 32'h30;
    bus.write   = WR_WORD;
    setData(32'h0A0B0C0D);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        check("hold_done_c0", 32'(bus.done), 32'd0);
      end else begin
        check($sformatf("hold_done_c%0d", c), 32'(bus.done), 32'd1);
      end
      if (c == 1) begin
        check("hold_read_first", readWord(), 32'h00000000);
      end
      @(negedge clk);
      if (c >= 1) begin
        bus.address = 32'h34;
      end
      setData($urandom);
    end
    bus.write = WR_NONE;
    @(posedge clk);
    #1;
    check("hold_done_release", 32'(bus.done), 32'd0);
    applyStimulus(32'h30, 32'h0A0B0C0D, 1'b0, "hold_rd_30");
    checkOutput();
    applyStimulus(32'h34, 32'h12345678, 1'b0, "hold_rd_34_untouched");
    checkOutput();

    // Reset landing in the WRITE cycle aborts the store.
    @(negedge clk);
    bus.address = 32'h40;
    bus.write   = WR_WORD;
    setData(32'hFFFFFFFF);
    @(posedge clk);
    #1;
    check("abort_done_in_write", 32'(bus.done), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_q_reset", readWord(), 32'h0);
    check("abort_done_reset", 32'(bus.done), 32'd0);
    @(negedge clk);
    bus.write = WR_NONE;
    @(posedge clk);
    #1;
    check("abort_done_held_reset", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_done_after", 32'(bus.done), 32'd0);
    applyStimulus(32'h40, 32'h99887766, 1'b0, "abort_rd_40_untouched");
    checkOutput();
    doStore(32'h44, WR_WORD, 32'h0BADF00D, 1'b0, "abort_next_store");
    applyStimulus(32'h44, 32'h0BADF00D, 1'b0, "abort_rd_44");
    checkOutput();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
